// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, the EX->MEM beat layout and the skid-buffer state encoding.
//   DATA_W / VDATA_W / REG_AW : scalar, vector and register-address widths
//   ex_mem_beat_t             : one EX->MEM beat, control bits first, then the data fields
//   skid_state_t              : occupancy of the two-entry skid buffer
package pipeline_pkg;
    localparam int DATA_W  = 32;
    localparam int VDATA_W = 128;
    localparam int REG_AW  = 4;

    typedef struct packed {
        logic               pcSrc;
        logic               regWrite;
        logic               memWrite;
        logic               memtoReg;
        logic               vec;
        logic [DATA_W-1:0]  aluResult;
        logic [DATA_W-1:0]  writeData;
        logic [VDATA_W-1:0] vResult;
        logic [REG_AW-1:0]  wa3;
    } ex_mem_beat_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
endpackage

// File: rtl/em_slot_reg.sv
// em_slot_reg: one storage slot of the EX->MEM skid buffer.
//   clk : rising-edge clock
//   rst : synchronous reset, active-low, clears the slot
//   en  : load d on this edge
//   d   : incoming beat
//   q   : stored beat
module em_slot_reg
    import pipeline_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  ex_mem_beat_t d,
    output ex_mem_beat_t q
);
    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/execute_memory_skid_buffer.sv
// execute_memory_skid_buffer: two-entry skid buffer at the EX->MEM boundary.
//   clk, rst          : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready : EX-side handshake; flush kills the beat currently offered
//   *E / *ECU inputs  : condition-gated control and results of the EX beat
//   out_valid/out_ready : MEM-side handshake
//   *M outputs        : head beat, forced to 0 whenever out_valid is low
module execute_memory_skid_buffer
    import pipeline_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic               PCSrcECU,
    input  logic               RegWriteECU,
    input  logic               MemWriteECU,
    input  logic               MemtoRegE,
    input  logic               VecE,
    input  logic [DATA_W-1:0]  ALUResultE,
    input  logic [DATA_W-1:0]  WriteDataE,
    input  logic [VDATA_W-1:0] VResultE,
    input  logic [REG_AW-1:0]  WA3E,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               PCSrcM,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic               MemtoRegM,
    output logic               VecM,
    output logic [DATA_W-1:0]  ALUResultM,
    output logic [DATA_W-1:0]  WriteDataM,
    output logic [VDATA_W-1:0] VResultM,
    output logic [REG_AW-1:0]  WA3M
);
    skid_state_t  state, stateNext;
    ex_mem_beat_t beatIn, slotA, slotB, slotAD, beatOut;
    logic         initDone, inFire, outFire, loadA, loadB;

    assign beatIn = '{PCSrcECU, RegWriteECU, MemWriteECU, MemtoRegE, VecE,
                      ALUResultE, WriteDataE, VResultE, WA3E};

    // initDone keeps in_ready low while reset is held and rises on the first
    // edge after release, so in_ready stays a pure register decode.
    assign in_ready  = initDone && state != TWO;
    assign out_valid = state != EMPTY;
    assign inFire    = in_valid && in_ready && !flush;
    assign outFire   = out_valid && out_ready;

    // A is refilled from the input while it is empty or draining with a new beat
    // arriving; from TWO it takes the skid entry.
    assign loadA  = (state == EMPTY && inFire) || (state == ONE && inFire && outFire) ||
                    (state == TWO && outFire);
    assign loadB  = state == ONE && inFire && !outFire;
    assign slotAD = state == TWO ? slotB : beatIn;

    always_comb begin
        stateNext = state;
        case (state)
            EMPTY:   stateNext = inFire ? ONE : EMPTY;
            ONE:     stateNext = (inFire && !outFire) ? TWO : (!inFire && outFire) ? EMPTY : ONE;
            TWO:     stateNext = outFire ? ONE : TWO;
            default: stateNext = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= EMPTY;
            initDone <= 1'b0;
        end else begin
            state    <= stateNext;
            initDone <= 1'b1;
        end
    end

    em_slot_reg uSlotA (.clk(clk), .rst(rst), .en(loadA), .d(slotAD), .q(slotA));
    em_slot_reg uSlotB (.clk(clk), .rst(rst), .en(loadB), .d(beatIn), .q(slotB));

    // Stale slot contents must never leak out as spurious write enables.
    assign beatOut = out_valid ? slotA : '0;
    assign {PCSrcM, RegWriteM, MemWriteM, MemtoRegM, VecM,
            ALUResultM, WriteDataM, VResultM, WA3M} = beatOut;
endmodule
